// File: rtl/tile_board_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tile_board_generator
// Description : Builds a CELLS-wide Memory Matrix board with exactly
//               min(tile_count, CELLS) lit cells. Cell positions come from a
//               free-running, seedable, maximal-length Fibonacci LFSR. A
//               bounded retry counter forces a deterministic fallback
//               placement, so every request terminates.
// Ports       :
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   request a new board (sampled only while idle)
//   tile_count in   number of lit cells, sampled with start
//   seed_load  in   load seed_in into the LFSR this cycle
//   seed_in    in   new LFSR seed; zero selects the default seed
//   busy       out  high while cells are being placed
//   done       out  one-cycle pulse when the board is final
//   board      out  cell map, bit i set = cell i lit
// Revision    : 1.0  initial release
// ============================================================================
module tile_board_generator #(
    parameter int          CELLS       = 16,
    parameter int          LFSR_W      = 16,
    parameter logic [31:0] SEED        = 32'h0000_ACE1,
    parameter int          RETRY_LIMIT = 64,
    localparam int         CNT_W       = $clog2(CELLS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  tile_count,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              busy,
    output logic              done,
    output logic [CELLS-1:0]  board
);

    localparam int                IDX_W        = $clog2(CELLS);
    localparam int                EXT_W        = 2 ** IDX_W;
    localparam logic [LFSR_W-1:0] c_seed       = SEED[LFSR_W-1:0];
    localparam logic [IDX_W:0]    c_cells_idx  = (IDX_W + 1)'(CELLS);
    localparam logic [CNT_W-1:0]  c_cells_cnt  = CNT_W'(CELLS);
    localparam logic [7:0]        c_retry_last = 8'(RETRY_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PICK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LFSR_W-1:0]  r_lfsr;
    logic               w_fb;
    logic [CELLS-1:0]   r_board;
    logic [CELLS-1:0]   w_board_next;
    logic [CNT_W-1:0]   r_placed;
    logic [CNT_W-1:0]   w_placed_next;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   w_target_next;
    logic [7:0]         r_retries;
    logic [7:0]         w_retries_next;
    logic [IDX_W-1:0]   w_idx;
    logic [EXT_W-1:0]   w_board_ext;
    logic               w_idx_free;
    logic [CELLS-1:0]   w_idx_onehot;
    logic [CELLS-1:0]   w_low_clear;

    // ------------------------------------------------------------------
    // Feedback taps for the supported maximal-length widths
    // ------------------------------------------------------------------
    generate
        if (LFSR_W == 8) begin : g_fb8
            assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
        end else if (LFSR_W == 16) begin : g_fb16
            assign w_fb = r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3];
        end else begin : g_fb32
            assign w_fb = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
        end
    endgenerate

    // The LFSR runs in every state; a seed load wins over the shift.
    // A zero seed would lock the register, so it maps to the default.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= c_seed;
        end else if (seed_load) begin
            r_lfsr <= (seed_in == '0) ? c_seed : seed_in;
        end else begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

    // Candidate cell from the pre-shift LFSR value. The board is widened
    // to a power of two so the lookup never indexes past its range; an
    // index beyond the real cells is rejected by the range compare.
    assign w_idx        = r_lfsr[IDX_W-1:0];
    assign w_board_ext  = EXT_W'(r_board);
    assign w_idx_free   = ({1'b0, w_idx} < c_cells_idx) && !w_board_ext[w_idx];
    assign w_idx_onehot = CELLS'(1) << w_idx;

    // Lowest clear bit as a one-hot: the +1 carry stops at the first zero.
    assign w_low_clear  = ~r_board & (r_board + CELLS'(1));

    always_comb begin
        w_state_next   = r_state;
        w_board_next   = r_board;
        w_placed_next  = r_placed;
        w_target_next  = r_target;
        w_retries_next = r_retries;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_board_next   = '0;
                    w_placed_next  = '0;
                    w_retries_next = '0;
                    w_target_next  = (tile_count > c_cells_cnt) ? c_cells_cnt : tile_count;
                    w_state_next   = S_PICK;
                end
            end
            S_PICK: begin
                if (r_placed == r_target) begin
                    w_state_next = S_DONE;
                end else if (w_idx_free) begin
                    w_board_next   = r_board | w_idx_onehot;
                    w_placed_next  = r_placed + CNT_W'(1);
                    w_retries_next = '0;
                end else if (r_retries == c_retry_last) begin
                    // placed < target <= CELLS, so a clear bit always exists
                    w_board_next   = r_board | w_low_clear;
                    w_placed_next  = r_placed + CNT_W'(1);
                    w_retries_next = '0;
                end else begin
                    w_retries_next = r_retries + 8'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_board   <= '0;
            r_placed  <= '0;
            r_target  <= '0;
            r_retries <= '0;
        end else begin
            r_state   <= w_state_next;
            r_board   <= w_board_next;
            r_placed  <= w_placed_next;
            r_target  <= w_target_next;
            r_retries <= w_retries_next;
        end
    end

    assign busy  = (r_state == S_PICK);
    assign done  = (r_state == S_DONE);
    assign board = r_board;

endmodule
`default_nettype wire

// File: tb/tb_tile_board_generator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tile_board_generator
// Description : Scoreboard bench. Three instances share reset, seed and
//               tile_count: the default configuration, CELLS=12, and
//               RETRY_LIMIT=1. Each start pushes the expected board, done
//               time and busy length; a monitor pops and compares on done.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tile_board_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start;
    logic [4:0]  tile_count;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [15:0] board0;
    logic [11:0] board1;
    logic [15:0] board2;

    always #5 clk = ~clk;

    tile_board_generator dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .tile_count(tile_count),
        .seed_load(seed_load), .seed_in(seed_in),
        .busy(busy[0]), .done(done[0]), .board(board0)
    );

    tile_board_generator #(.CELLS(12)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .tile_count(tile_count[3:0]),
        .seed_load(seed_load), .seed_in(seed_in),
        .busy(busy[1]), .done(done[1]), .board(board1)
    );

    tile_board_generator #(.RETRY_LIMIT(1)) dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .tile_count(tile_count),
        .seed_load(seed_load), .seed_in(seed_in),
        .busy(busy[2]), .done(done[2]), .board(board2)
    );

    typedef struct {
        int          id;
        logic [15:0] board;
        int          pop;
        int          done_edge;
        int          n_pick;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    int          busy_run[3];
    int          ref_edge;
    logic [15:0] ref_base;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] board_of(input int id);
        if (id == 0) return board0;
        if (id == 1) return {4'h0, board1};
        return board2;
    endfunction

    function automatic logic [15:0] lf_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
    endfunction

    // Behavioural reference: s shifts from the last known LFSR value, then
    // one pick per cycle until the target is met (final cycle counted).
    task automatic model(input int s, input int tc, input int cells, input int rlim,
                         output logic [15:0] b, output int n_pick);
        logic [15:0] l;
        int          tgt, placed, retries, idx;
        l = ref_base;
        repeat (s) l = lf_step(l);
        tgt = (tc > cells) ? cells : tc;
        b = '0; placed = 0; retries = 0; n_pick = 0;
        for (int k = 0; k < 5000; k++) begin
            n_pick++;
            if (placed == tgt) break;
            idx = int'(l[3:0]);
            if (idx < cells && !b[idx]) begin
                b[idx] = 1'b1; placed++; retries = 0;
            end else if (retries == rlim - 1) begin
                for (int j = 0; j < cells; j++) begin
                    if (!b[j]) begin b[j] = 1'b1; break; end
                end
                placed++; retries = 0;
            end else begin
                retries++;
            end
            l = lf_step(l);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (busy[i]) begin
                busy_run[i]++;
            end else if (done[i]) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: dut=%0d actual=1 expected=0 (t=%0t)", i, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("done_dut_id", i, e.id);
                    check("board", board_of(i), e.board);
                    check("popcount", $countones(board_of(i)), e.pop);
                    check("done_edge", edge_cnt, e.done_edge);
                    check("busy_cycles", busy_run[i], e.n_pick);
                end
                busy_run[i] = 0;
            end else begin
                busy_run[i] = 0;
            end
        end
    end

    task automatic load_seed(input logic [15:0] x);
        seed_load = 1'b1;
        seed_in   = x;
        ref_edge  = edge_cnt + 1;
        ref_base  = (x == 16'h0) ? 16'hACE1 : x;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    // Called at a falling edge; start is sampled at edge edge_cnt+1
    task automatic issue(input int id, input int tc, input bit push);
        exp_t        e;
        logic [15:0] b;
        int          np, e_s;
        e_s = edge_cnt + 1;
        model(e_s - ref_edge, tc, (id == 1) ? 12 : 16, (id == 2) ? 1 : 64, b, np);
        if (push) begin
            e.id = id; e.board = b; e.pop = $countones(b);
            e.done_edge = e_s + np; e.n_pick = np;
            exp_q.push_back(e);
        end
        start[id]  = 1'b1;
        tile_count = 5'(tc);
        @(negedge clk);
        start = '0;
    endtask

    task automatic wait_all();
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: actual=pending expected=done (t=%0t)", $time);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input int id, input int tc);
        issue(id, tc, 1'b1);
        wait_all();
    endtask

    initial begin
        reset = 1'b0; start = '0; tile_count = '0; seed_load = 1'b0; seed_in = '0;
        busy_run = '{0, 0, 0};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_board", board_of(i), 16'h0);
            check("reset_busy", busy[i], 1'b0);
            check("reset_done", done[i], 1'b0);
        end
        reset = 1'b1;
        ref_edge = edge_cnt;
        ref_base = 16'hACE1;
        @(negedge clk);
        check("lfsr_first", dut0.r_lfsr, 16'h59C3);
        @(negedge clk);
        check("lfsr_second", dut0.r_lfsr, 16'hB386);

        // Seeded run, repeated with identical timing
        load_seed(16'h1234); @(negedge clk); run(0, 5);
        load_seed(16'h1234); @(negedge clk); run(0, 5);

        // Empty board, clamped full boards, non-power-of-two board
        run(0, 0);
        run(0, 20);
        run(1, 12);

        // Every rejection falls back immediately
        run(2, 16);

        // Zero seed selects the default seed
        load_seed(16'h0000); run(0, 7);

        // A second start mid-run is ignored
        issue(0, 10, 1'b1);
        repeat (3) @(negedge clk);
        start[0] = 1'b1; tile_count = 5'd3;
        @(negedge clk);
        start[0] = 1'b0;
        wait_all();

        // Asynchronous reset mid-run: no done, everything clears at once
        issue(0, 16, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_before_reset", busy[0], 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_board", board0, 16'h0);
        check("async_busy", busy[0], 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ref_edge = edge_cnt;
        ref_base = 16'hACE1;
        @(negedge clk);
        run(0, 4);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
